regfile_wb_sched: RTL and testbench
===================================

Name: regfile_wb_sched

Overview:
- Writeback scheduler for the 32x32 register file (two read ports, one write port, x0 hardwired to zero).
- Shares the single write port between NUM_REQ writeback requesters (ALU, load unit, PID/motor accelerator) using round-robin valid/ready arbitration.
- Keeps a pending-write scoreboard and raises a hazard stall for the issue stage.
- Drives the register file's w_en/rd/wd from a registered output stage.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8).
- XLEN, 32, data width.
- AW, 5, register index width (32 registers).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  requester i has a writeback.
- req_ready  out  NUM_REQ  requester i granted this cycle.
- req_rd  in  NUM_REQ*AW  destination index, slice i.
- req_wd  in  NUM_REQ*XLEN  write data, slice i.
- w_en  out  1  register file write enable (registered).
- rd  out  AW  register file write index (registered).
- wd  out  XLEN  register file write data (registered).
- issue_valid  in  1  issue stage dispatches an instruction writing issue_rd.
- issue_rd  in  AW  destination of the issuing instruction.
- chk_rs1, chk_rs2, chk_rd  in  AW each  operands of the instruction in decode.
- stall  out  1  hazard on a decode operand.
- pending  out  32  scoreboard bit vector.
- wb_err  out  1  sticky: writeback to a non-pending register.

Behaviour:
- Reset (any cycle, including mid-operation):
  - w_en=0, rd=0, wd=0, pending=0, wb_err=0, round-robin pointer=0.
  - An accepted but uncommitted write is discarded.
- Arbitration:
  - Combinational. Among asserted req_valid, grant the first index at or after ptr, wrapping modulo NUM_REQ.
  - req_ready is one-hot or all-zero.
  - A transfer occurs when req_valid[i] & req_ready[i].
  - On a transfer, ptr <= granted index + 1, wrapping to 0 after NUM_REQ-1. With no transfer, ptr holds.
  - Requester contract: hold valid, rd and wd stable until ready. The bench asserts this contract.
- Output stage:
  - On a transfer with req_rd != 0: w_en<=1, rd<=req_rd, wd<=req_wd. The register file writes at the following edge, so commit latency is 2 edges from the accept edge.
  - On a transfer with req_rd == 0: accepted, w_en<=0, no scoreboard change.
  - With no transfer: w_en<=0; rd and wd hold.
- Scoreboard:
  - Set: at an edge where issue_valid & issue_rd != 0, pending[issue_rd] <= 1.
  - Clear: at an edge where w_en=1, pending[rd] <= 0.
  - Set and clear of the same index at the same edge: set wins.
  - pending[0] is always 0.
- Write-after-write: a second issue to an already-pending rd is legal. The bit stays set and clears on the first matching commit. Issue must stall via chk_rd to avoid this case.
- stall (combinational) = pending[chk_rs1] | pending[chk_rs2] | pending[chk_rd], where index 0 contributes 0.
- wb_err: set when w_en=1 and pending[rd]=0 at an edge. Cleared only by rst.
- No internal FSM beyond the ptr and output registers. The block never backpressures all requesters: at least one valid requester is granted every cycle.

Optional Feature:
- Macro: REGFILE_WB_FWD_EN.
- Defined:
  - Adds outputs fwd1_hit, fwd2_hit (1 bit each) and fwd_data (XLEN).
  - When w_en=1 and rd==chk_rs1 (rd!=0), fwd1_hit=1 and pending[chk_rs1] is masked out of stall. Same rule for chk_rs2 with fwd2_hit.
  - fwd_data = wd.
  - chk_rd masking is not affected.
- Undefined: no forwarding ports; stall exactly as specified above.

Test Plan:
- Reset then idle: rst high 2 cycles -> w_en=0, pending=0, stall=0, wb_err=0, req_ready=0.
- Single write: issue_rd=5; next cycle req0 valid rd=5 wd=0xDEADBEEF -> req_ready[0]=1 same cycle; w_en=1, rd=5, wd=0xDEADBEEF one edge later; pending[5] 1->0 at the following edge; chk_rs1=5 stalls until then.
- Round-robin fairness: regs 1,2,3 pending; all 3 requesters valid continuously, distinct rd=1,2,3 -> grants in order 0,1,2, then idle; w_en high 3 consecutive cycles; no wb_err.
- Simultaneous set and clear: w_en commit to rd=7 at the same edge as issue_rd=7 -> pending[7] remains 1.
- x0 handling: issue_rd=0 and req rd=0 wd=0x1234 -> accepted, w_en stays 0, pending[0]=0, stall=0 with chk_rs1=0.
- Reset mid-flight: req accepted for rd=9, rst asserted the next edge -> w_en=0, pending[9]=0; with REGFILE_WB_FWD_EN, chk_rs1=9 while w_en=1 rd=9 gives fwd1_hit=1 and stall=0.

Source files
------------

// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched
// ----------------
// Writeback scheduler for a 32x32 register file. It has one write port, and
// x0 is hardwired to zero. NUM_REQ writeback requesters (ALU, load unit,
// PID/motor accelerator) share the single write port through round-robin
// valid/ready arbitration. The winning request is registered, and that
// register drives the register file's w_en/rd/wd.
//
// A pending-write scoreboard tracks destinations that have been issued but
// not yet committed. The scoreboard produces a hazard stall for the decode
// stage.
//
// Optional feature (macro REGFILE_WB_FWD_EN): adds forwarding outputs
// fwd1_hit, fwd2_hit and fwd_data. A source operand that matches the write
// currently being committed is then masked out of the stall.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   req_valid/req_ready per-requester handshake (ready is one-hot or zero)
//   req_rd, req_wd      packed per-requester destination index / data
//   w_en, rd, wd        registered register-file write port
//   issue_valid/rd      issue stage marks issue_rd as pending
//   chk_rs1/rs2/rd      decode operands checked for hazards
//   stall               hazard on a decode operand
//   pending             scoreboard bit vector
//   wb_err              sticky: commit to a register that was not pending
//   fwd1_hit, fwd2_hit, fwd_data   (REGFILE_WB_FWD_EN only)

module regfile_wb_sched #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = 32,
    parameter int AW      = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*AW-1:0]   req_rd,
    input  logic [NUM_REQ*XLEN-1:0] req_wd,
    output logic                    w_en,
    output logic [AW-1:0]           rd,
    output logic [XLEN-1:0]         wd,
    input  logic                    issue_valid,
    input  logic [AW-1:0]           issue_rd,
    input  logic [AW-1:0]           chk_rs1,
    input  logic [AW-1:0]           chk_rs2,
    input  logic [AW-1:0]           chk_rd,
    output logic                    stall,
    output logic [(1<<AW)-1:0]      pending,
`ifdef REGFILE_WB_FWD_EN
    output logic                    fwd1_hit,
    output logic                    fwd2_hit,
    output logic [XLEN-1:0]         fwd_data,
`endif
    output logic                    wb_err
);

    localparam int NREG = 1 << AW;
    localparam int PW   = $clog2(NUM_REQ);

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   grant_idx;
    logic            grant_any;
    int              arb_idx;
    logic [AW-1:0]   sel_rd;
    logic [XLEN-1:0] sel_wd;
    logic [NREG-1:0] pending_next;
    logic            haz1;
    logic            haz2;
    logic            haz3;

    // Round-robin search: scan from ptr upward and wrap modulo NUM_REQ.
    // The first valid requester wins. Because some valid requester is always
    // granted, a transfer happens every cycle that any valid is asserted.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        arb_idx   = 0;
        req_ready = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            arb_idx = int'(ptr) + k;
            if (arb_idx >= NUM_REQ) begin
                arb_idx = arb_idx - NUM_REQ;
            end
            if (!grant_any && req_valid[arb_idx]) begin
                grant_any = 1'b1;
                grant_idx = PW'(arb_idx);
            end
        end
        if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign sel_rd = req_rd[int'(grant_idx)*AW +: AW];
    assign sel_wd = req_wd[int'(grant_idx)*XLEN +: XLEN];

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant_any) begin
            ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    // A write to x0 is accepted but never reaches the register file.
    // rd and wd keep their old values on idle cycles, and fwd_data relies on that.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_en <= 1'b0;
            rd   <= '0;
            wd   <= '0;
        end else if (grant_any && sel_rd != '0) begin
            w_en <= 1'b1;
            rd   <= sel_rd;
            wd   <= sel_wd;
        end else begin
            w_en <= 1'b0;
        end
    end

    // The clear is applied before the set, so an issue to a register wins
    // over a commit to the same register at the same edge.
    always_comb begin
        pending_next = pending;
        if (w_en) begin
            pending_next[rd] = 1'b0;
        end
        if (issue_valid && issue_rd != '0) begin
            pending_next[issue_rd] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            wb_err  <= 1'b0;
        end else begin
            pending <= pending_next;
            if (w_en && !pending[rd]) begin
                wb_err <= 1'b1;
            end
        end
    end

`ifdef REGFILE_WB_FWD_EN
    // A source that matches the write being committed now can take its value
    // from the write bus. chk_rd still stalls, because forwarding does not
    // resolve a write-after-write hazard.
    assign fwd1_hit = w_en && (rd != '0) && (rd == chk_rs1);
    assign fwd2_hit = w_en && (rd != '0) && (rd == chk_rs2);
    assign fwd_data = wd;
    assign haz1 = (chk_rs1 != '0) && pending[chk_rs1] && !fwd1_hit;
    assign haz2 = (chk_rs2 != '0) && pending[chk_rs2] && !fwd2_hit;
`else
    assign haz1 = (chk_rs1 != '0) && pending[chk_rs1];
    assign haz2 = (chk_rs2 != '0) && pending[chk_rs2];
`endif
    assign haz3  = (chk_rd != '0) && pending[chk_rd];
    assign stall = haz1 | haz2 | haz3;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// tb_regfile_wb_sched
// -------------------
// Directed testbench for regfile_wb_sched (NUM_REQ=3, XLEN=32, AW=5).
//
// Stimulus pushes each expected register-file write {rd, wd} into a queue.
// A monitor pops one entry every time the DUT presents w_en and compares it.
// Combinational and state outputs are checked directly against
// hand-computed values.
//
// Define REGFILE_WB_FWD_EN to build the bench against the forwarding
// variant.

module tb_regfile_wb_sched;

    localparam int NUM_REQ = 3;
    localparam int XLEN    = 32;
    localparam int AW      = 5;

    logic                    clk;
    logic                    rst;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*AW-1:0]   req_rd;
    logic [NUM_REQ*XLEN-1:0] req_wd;
    logic                    w_en;
    logic [AW-1:0]           rd;
    logic [XLEN-1:0]         wd;
    logic                    issue_valid;
    logic [AW-1:0]           issue_rd;
    logic [AW-1:0]           chk_rs1;
    logic [AW-1:0]           chk_rs2;
    logic [AW-1:0]           chk_rd;
    logic                    stall;
    logic [31:0]             pending;
    logic                    wb_err;
`ifdef REGFILE_WB_FWD_EN
    logic                    fwd1_hit;
    logic                    fwd2_hit;
    logic [XLEN-1:0]         fwd_data;
`endif

    int          vectors;
    int          miscompares;
    logic [36:0] exp_q[$];
    logic [36:0] mon_exp;

    logic [NUM_REQ-1:0]      prev_valid;
    logic [NUM_REQ-1:0]      prev_ready;
    logic [NUM_REQ*AW-1:0]   prev_rd;
    logic [NUM_REQ*XLEN-1:0] prev_wd;
    logic                    have_prev;

    regfile_wb_sched #(
        .NUM_REQ(NUM_REQ),
        .XLEN   (XLEN),
        .AW     (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rd     (req_rd),
        .req_wd     (req_wd),
        .w_en       (w_en),
        .rd         (rd),
        .wd         (wd),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .chk_rs1    (chk_rs1),
        .chk_rs2    (chk_rs2),
        .chk_rd     (chk_rd),
        .stall      (stall),
        .pending    (pending),
`ifdef REGFILE_WB_FWD_EN
        .fwd1_hit   (fwd1_hit),
        .fwd2_hit   (fwd2_hit),
        .fwd_data   (fwd_data),
`endif
        .wb_err     (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
        end
    endtask

    task automatic applyStimulus(input int i, input logic v, input logic [AW-1:0] r, input logic [XLEN-1:0] d);
        req_valid[i]            = v;
        req_rd[i*AW +: AW]      = r;
        req_wd[i*XLEN +: XLEN]  = d;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Scoreboard monitor: every committed write must match the oldest expected one.
    always @(negedge clk) begin
        if (w_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL wb_unexpected: got write rd=%0d wd=0x%08h, expected no write", rd, wd);
            end else begin
                mon_exp = exp_q.pop_front();
                checkOutput("wb_rd", 32'(rd), 32'(mon_exp[36:32]));
                checkOutput("wb_wd", wd, mon_exp[31:0]);
            end
        end
    end

    // Requester contract: a valid that was not granted must persist unchanged.
    always @(posedge clk) begin
        if (!rst && have_prev) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (prev_valid[i] && !prev_ready[i]) begin
                    vectors++;
                    if (!req_valid[i] || req_rd[i*AW +: AW] !== prev_rd[i*AW +: AW]
                        || req_wd[i*XLEN +: XLEN] !== prev_wd[i*XLEN +: XLEN]) begin
                        miscompares++;
                        $display("[TB] FAIL contract_req%0d: got valid=%0b after ungranted cycle, expected held request", i, req_valid[i]);
                    end
                end
            end
        end
        prev_valid <= req_valid;
        prev_ready <= req_ready;
        prev_rd    <= req_rd;
        prev_wd    <= req_wd;
        have_prev  <= !rst;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        have_prev   = 1'b0;
        rst         = 1'b1;
        req_valid   = '0;
        req_rd      = '0;
        req_wd      = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        chk_rs1     = '0;
        chk_rs2     = '0;
        chk_rd      = '0;

        // Reset for two cycles, then idle
        step();
        step();
        rst = 1'b0;
        #1;
        checkOutput("rst_w_en", 32'(w_en), 32'd0);
        checkOutput("rst_pending", pending, 32'd0);
        checkOutput("rst_stall", 32'(stall), 32'd0);
        checkOutput("rst_wb_err", 32'(wb_err), 32'd0);
        checkOutput("rst_ready", 32'(req_ready), 32'd0);

        // Single write to x5
        issue_valid = 1'b1;
        issue_rd    = 5'd5;
        step();
        issue_valid = 1'b0;
        applyStimulus(0, 1'b1, 5'd5, 32'hDEADBEEF);
        chk_rs1 = 5'd5;
        #1;
        checkOutput("single_ready", 32'(req_ready), 32'b001);
        checkOutput("single_pending_set", pending, 32'h0000_0020);
        checkOutput("single_stall_pre", 32'(stall), 32'd1);
        exp_q.push_back({5'd5, 32'hDEADBEEF});
        step();
        applyStimulus(0, 1'b0, 5'd0, 32'h0);
        #1;
        checkOutput("single_w_en", 32'(w_en), 32'd1);
        checkOutput("single_pending_hold", pending, 32'h0000_0020);
`ifdef REGFILE_WB_FWD_EN
        checkOutput("single_stall_fwd", 32'(stall), 32'd0);
        checkOutput("single_fwd1_hit", 32'(fwd1_hit), 32'd1);
        checkOutput("single_fwd2_hit", 32'(fwd2_hit), 32'd0);
`else
        checkOutput("single_stall_commit", 32'(stall), 32'd1);
`endif
        step();
        #1;
        checkOutput("single_pending_clr", pending, 32'd0);
        checkOutput("single_stall_post", 32'(stall), 32'd0);
        checkOutput("single_w_en_off", 32'(w_en), 32'd0);
        checkOutput("single_wb_err", 32'(wb_err), 32'd0);
        chk_rs1 = 5'd0;

        // Reset to return the pointer to 0, then check round-robin fairness
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int r = 1; r <= 3; r++) begin
            issue_valid = 1'b1;
            issue_rd    = 5'(r);
            step();
        end
        issue_valid = 1'b0;
        #1;
        checkOutput("rr_pending_set", pending, 32'h0000_000E);
        applyStimulus(0, 1'b1, 5'd1, 32'hA1A1_0001);
        applyStimulus(1, 1'b1, 5'd2, 32'hA2A2_0002);
        applyStimulus(2, 1'b1, 5'd3, 32'hA3A3_0003);
        #1;
        checkOutput("rr_grant0", 32'(req_ready), 32'b001);
        exp_q.push_back({5'd1, 32'hA1A1_0001});
        step();
        applyStimulus(0, 1'b0, 5'd0, 32'h0);
        #1;
        checkOutput("rr_grant1", 32'(req_ready), 32'b010);
        checkOutput("rr_w_en_1", 32'(w_en), 32'd1);
        exp_q.push_back({5'd2, 32'hA2A2_0002});
        step();
        applyStimulus(1, 1'b0, 5'd0, 32'h0);
        #1;
        checkOutput("rr_grant2", 32'(req_ready), 32'b100);
        checkOutput("rr_w_en_2", 32'(w_en), 32'd1);
        exp_q.push_back({5'd3, 32'hA3A3_0003});
        step();
        applyStimulus(2, 1'b0, 5'd0, 32'h0);
        #1;
        checkOutput("rr_idle_ready", 32'(req_ready), 32'd0);
        checkOutput("rr_w_en_3", 32'(w_en), 32'd1);
        checkOutput("rr_pending_mid", pending, 32'h0000_0008);
        step();
        #1;
        checkOutput("rr_w_en_off", 32'(w_en), 32'd0);
        checkOutput("rr_pending_clr", pending, 32'd0);
        checkOutput("rr_wb_err", 32'(wb_err), 32'd0);

        // x0 handling: requests to x0 are accepted without writing. The pointer
        // has wrapped to 0, so req0 wins first and req2 wins next.
        issue_valid = 1'b1;
        issue_rd    = 5'd0;
        applyStimulus(0, 1'b1, 5'd0, 32'h0000_1234);
        applyStimulus(2, 1'b1, 5'd0, 32'h0000_5678);
        #1;
        checkOutput("x0_grant0", 32'(req_ready), 32'b001);
        checkOutput("x0_stall", 32'(stall), 32'd0);
        step();
        issue_valid = 1'b0;
        applyStimulus(0, 1'b0, 5'd0, 32'h0);
        #1;
        checkOutput("x0_grant2", 32'(req_ready), 32'b100);
        checkOutput("x0_w_en", 32'(w_en), 32'd0);
        checkOutput("x0_pending", pending, 32'd0);
        step();
        applyStimulus(2, 1'b0, 5'd0, 32'h0);
        #1;
        checkOutput("x0_w_en_2", 32'(w_en), 32'd0);
        checkOutput("x0_pending_2", pending, 32'd0);

        // Set and clear of x7 at the same edge: the set wins
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        step();
        issue_valid = 1'b0;
        applyStimulus(1, 1'b1, 5'd7, 32'h0000_0077);
        #1;
        checkOutput("sc_grant1", 32'(req_ready), 32'b010);
        exp_q.push_back({5'd7, 32'h0000_0077});
        step();
        applyStimulus(1, 1'b0, 5'd0, 32'h0);
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        #1;
        checkOutput("sc_w_en", 32'(w_en), 32'd1);
        checkOutput("sc_pending_pre", pending, 32'h0000_0080);
        step();
        issue_valid = 1'b0;
        chk_rd      = 5'd7;
        #1;
        checkOutput("sc_pending_kept", pending, 32'h0000_0080);
        checkOutput("sc_stall_rd", 32'(stall), 32'd1);
        checkOutput("sc_wb_err", 32'(wb_err), 32'd0);
        chk_rd = 5'd0;
        // The pointer is at 2, so a lone req0 wins after the wrap
        applyStimulus(0, 1'b1, 5'd7, 32'h0000_0088);
        #1;
        checkOutput("sc_grant_wrap", 32'(req_ready), 32'b001);
        exp_q.push_back({5'd7, 32'h0000_0088});
        step();
        applyStimulus(0, 1'b0, 5'd0, 32'h0);
        step();
        #1;
        checkOutput("sc_pending_clr", pending, 32'd0);

        // A commit to a register that is not pending sets the sticky wb_err
        applyStimulus(2, 1'b1, 5'd10, 32'h0000_0A0A);
        #1;
        checkOutput("err_grant2", 32'(req_ready), 32'b100);
        exp_q.push_back({5'd10, 32'h0000_0A0A});
        step();
        applyStimulus(2, 1'b0, 5'd0, 32'h0);
        #1;
        checkOutput("err_before", 32'(wb_err), 32'd0);
        step();
        #1;
        checkOutput("err_set", 32'(wb_err), 32'd1);
        step();
        #1;
        checkOutput("err_sticky", 32'(wb_err), 32'd1);

        // Reset while a write to x9 is in the output stage
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        step();
        issue_valid = 1'b0;
        applyStimulus(0, 1'b1, 5'd9, 32'h0000_0999);
        chk_rs1 = 5'd9;
        #1;
        checkOutput("mid_grant0", 32'(req_ready), 32'b001);
        exp_q.push_back({5'd9, 32'h0000_0999});
        step();
        applyStimulus(0, 1'b0, 5'd0, 32'h0);
        rst = 1'b1;
        #1;
        checkOutput("mid_w_en", 32'(w_en), 32'd1);
`ifdef REGFILE_WB_FWD_EN
        checkOutput("mid_fwd1_hit", 32'(fwd1_hit), 32'd1);
        checkOutput("mid_fwd_data", fwd_data, 32'h0000_0999);
        checkOutput("mid_stall_fwd", 32'(stall), 32'd0);
`else
        checkOutput("mid_stall", 32'(stall), 32'd1);
`endif
        step();
        rst = 1'b0;
        #1;
        checkOutput("mid_w_en_off", 32'(w_en), 32'd0);
        checkOutput("mid_pending", pending, 32'd0);
        checkOutput("mid_rd", 32'(rd), 32'd0);
        checkOutput("mid_wd", wd, 32'd0);
        checkOutput("mid_wb_err", 32'(wb_err), 32'd0);
        checkOutput("mid_stall_clr", 32'(stall), 32'd0);
        chk_rs1 = 5'd0;

        step();
        #1;
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
